bht_port_sched: RTL and testbench
=================================

// Module: bht_port_sched
// PURPOSE
//  Scheduler for a single-port BHT counter SRAM; arbitrates frontend lookups against resolved-branch updates.
//  Performs the post-reset/flush init walk and buffers updates in a small FIFO.
//  Executes each update as a read-modify-write of a saturating counter.
//  Sits between frontend/branch-unit and the BHT SRAM macro.
// PARAMETERS
//  NR_ENTRIES      1024  counters in the BHT SRAM (power of 2)
//  CTR_W           2     saturating counter width
//  UPD_DEPTH       4     update FIFO depth (power of 2, >=2)
//  INIT_VAL        1     counter value written during init (weakly not-taken)
// PORTS
//  clk_i           in   1                    clock
//  rst_i           in   1                    async reset, active-high
//  flush_bht_i     in   1                    request full BHT re-init
//  lookup_valid_i  in   1                    lookup request
//  lookup_index_i  in   $clog2(NR_ENTRIES)   lookup index
//  lookup_ready_o  out  1                    lookup accepted this cycle (valid&ready)
//  lookup_rvalid_o out  1                    lookup response valid
//  lookup_ctr_o    out  CTR_W                counter read
//  lookup_taken_o  out  1                    prediction = lookup_ctr_o[CTR_W-1]
//  upd_valid_i     in   1                    resolved conditional branch
//  upd_index_i     in   $clog2(NR_ENTRIES)   index to update
//  upd_taken_i     in   1                    resolved direction
//  upd_ready_o     out  1                    FIFO not full
//  init_busy_o     out  1                    init walk in progress
//  sram_req_o      out  1                    SRAM access
//  sram_we_o       out  1                    1=write
//  sram_addr_o     out  $clog2(NR_ENTRIES)   SRAM address
//  sram_wdata_o    out  CTR_W                write data
//  sram_rdata_i    in   CTR_W                read data, valid 1 cycle after read req
//  stat_stall_o    out  32                   lookup cycles stalled by updates/init
//  stat_upd_o      out  32                   updates committed
// BEHAVIOUR
//  Reset: state=INIT, init ptr=0, FIFO empty; all outputs 0 except init_busy_o=1, upd_ready_o=0.
//  FSM INIT: each cycle write INIT_VAL at ptr, ptr++; after ptr=NR_ENTRIES-1 go RUN. lookup_ready_o=0, upd_ready_o=0.
//  FSM RUN, priority per cycle: (a) FIFO full -> RMW read of FIFO head; (b) lookup_valid_i -> lookup read;
//   (c) FIFO non-empty -> RMW read of head; else idle. Granting an RMW read moves to UPD_WR.
//  UPD_WR (exactly 1 cycle): write sat(rdata) to the held index, pop FIFO, go RUN; lookup_ready_o=0.
//  Saturation: taken & ctr!=max -> +1; !taken & ctr!=0 -> -1; otherwise unchanged.
//  Lookup: accepted cycle T -> lookup_rvalid_o=1 at T+1, single-cycle pulse; back-to-back lookups sustain 1/cycle.
//  Lookup during a pending RMW of the same index returns the pre-update value; no forwarding.
//  FIFO push when upd_valid_i & upd_ready_o; push and pop in the same cycle are allowed when full.
//  Updates with upd_ready_o=0 are lost; the upstream accepts the loss.
//  flush_bht_i: in RUN/UPD_WR, finish any UPD_WR write, then discard the FIFO, ptr=0, enter INIT.
//   Not yet returned lookup_rvalid_o still fires. In INIT, flush restarts the walk at 0.
//  rst_i mid-operation: immediate return to reset state; walk restarts at 0.
// CONFIGURATION
//  BHT_SCHED_STATS_EN defined: stat_stall_o counts cycles with lookup_valid_i & !lookup_ready_o.
//   stat_upd_o counts UPD_WR cycles. Both wrap at 2^32 and clear only on rst_i.
//  Not defined: both stat outputs tied to 0, counters not synthesised. Ports are present in both builds.
// STRUCTURE
//  bht_sched_pkg: state_e {INIT, RUN, UPD_WR}; upd_entry_t {index, taken}; sat_update() function.
//  Sub-module bht_upd_fifo: UPD_DEPTH x upd_entry_t, full/empty/push/pop, async active-high reset.
// TESTING
//  1 Reset, NR_ENTRIES=16 -> 16 writes of 1 to addr 0..15, init_busy_o falls after cycle 16, lookup_ready_o rises.
//  2 Lookup idx 5 after init -> rvalid next cycle, ctr=1, taken=0.
//  3 Three updates idx 5 taken, idle -> ctr 1->2->3->3; stat_upd_o=3 if BHT_SCHED_STATS_EN.
//  4 FIFO full (4 updates) with continuous lookups -> one RMW forced, lookup stalled 2 cycles.
//    stat_stall_o=2; upd_ready_o goes high next cycle.
//  5 Lookup stream every cycle with 2 queued updates -> updates drain only after lookups stop, unless FIFO fills.
//  6 flush_bht_i during UPD_WR -> write completes, FIFO emptied, INIT restarts at 0, counters all 1 afterward.

Source files
------------

// File: rtl/bht_sched_pkg.sv
// Shared types and helpers for the BHT port scheduler: FSM states, queued update entry,
// and the saturating-counter step applied during read-modify-write.
package bht_sched_pkg;

  // Widest index/counter the shared types can carry; instances use the low bits.
  localparam int IDX_W_MAX = 16;
  localparam int CTR_W_MAX = 8;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    UPD_WR
  } state_e;

  typedef struct packed {
    logic [IDX_W_MAX-1:0] index;
    logic                 taken;
  } upd_entry_t;

  function automatic logic [CTR_W_MAX-1:0] sat_update(
    input logic [CTR_W_MAX-1:0] ctr,
    input logic [CTR_W_MAX-1:0] ctr_max,
    input logic                 taken
  );
    logic [CTR_W_MAX-1:0] res;
    res = ctr;
    if (taken && (ctr != ctr_max)) begin
      res = ctr + 1'b1;
    end else if (!taken && (ctr != '0)) begin
      res = ctr - 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Small circular FIFO holding resolved-branch updates until the SRAM port is free.
// Push while full is accepted when a pop happens in the same cycle; clear_i empties it.
module bht_upd_fifo
  import bht_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       clear_i,
  input  upd_entry_t din_i,
  output upd_entry_t dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  upd_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem[rd_ptr_q];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/bht_port_sched.sv
// Single-port BHT SRAM scheduler: init walk, lookup/update arbitration, counter RMW.
// Optional statistics counters are built when BHT_SCHED_STATS_EN is defined.
module bht_port_sched
  import bht_sched_pkg::*;
#(
  parameter int               NR_ENTRIES = 1024,
  parameter int               CTR_W      = 2,
  parameter int               UPD_DEPTH  = 4,
  parameter logic [CTR_W-1:0] INIT_VAL   = CTR_W'(1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_bht_i,
  input  logic                          lookup_valid_i,
  input  logic [$clog2(NR_ENTRIES)-1:0] lookup_index_i,
  output logic                          lookup_ready_o,
  output logic                          lookup_rvalid_o,
  output logic [CTR_W-1:0]              lookup_ctr_o,
  output logic                          lookup_taken_o,
  input  logic                          upd_valid_i,
  input  logic [$clog2(NR_ENTRIES)-1:0] upd_index_i,
  input  logic                          upd_taken_i,
  output logic                          upd_ready_o,
  output logic                          init_busy_o,
  output logic                          sram_req_o,
  output logic                          sram_we_o,
  output logic [$clog2(NR_ENTRIES)-1:0] sram_addr_o,
  output logic [CTR_W-1:0]              sram_wdata_o,
  input  logic [CTR_W-1:0]              sram_rdata_i,
  output logic [31:0]                   stat_stall_o,
  output logic [31:0]                   stat_upd_o
);

  localparam int               IDX_W    = $clog2(NR_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             lookup_rv_q;
  logic             req_c, we_c, lookup_ready_c;
  logic [IDX_W-1:0] addr_c;
  logic [CTR_W-1:0] wdata_c;
  logic             fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
  upd_entry_t       head;
  logic [IDX_W-1:0] head_idx;
  logic             unused_idx_hi;

  assign head_idx      = head.index[IDX_W-1:0];
  assign unused_idx_hi = ^head.index;

  // The entry being read/written stays at the FIFO head until UPD_WR pops it.
  bht_upd_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (fifo_clear),
    .din_i   ('{index: IDX_W_MAX'(upd_index_i), taken: upd_taken_i}),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= INIT;
      ptr_q       <= '0;
      lookup_rv_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lookup_rv_q <= lookup_ready_c;
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    req_c          = 1'b0;
    we_c           = 1'b0;
    addr_c         = '0;
    wdata_c        = '0;
    lookup_ready_c = 1'b0;
    fifo_pop       = 1'b0;
    fifo_clear     = 1'b0;
    case (state_q)
      INIT: begin
        req_c   = 1'b1;
        we_c    = 1'b1;
        addr_c  = ptr_q;
        wdata_c = INIT_VAL;
        if (flush_bht_i) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_IDX) begin
          ptr_d   = '0;
          state_d = RUN;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      RUN: begin
        if (flush_bht_i) begin
          fifo_clear = 1'b1;
          ptr_d      = '0;
          state_d    = INIT;
        end else if (fifo_full) begin
          req_c   = 1'b1;
          addr_c  = head_idx;
          state_d = UPD_WR;
        end else if (lookup_valid_i) begin
          req_c          = 1'b1;
          addr_c         = lookup_index_i;
          lookup_ready_c = 1'b1;
        end else if (!fifo_empty) begin
          req_c   = 1'b1;
          addr_c  = head_idx;
          state_d = UPD_WR;
        end
      end
      UPD_WR: begin
        req_c    = 1'b1;
        we_c     = 1'b1;
        addr_c   = head_idx;
        wdata_c  = CTR_W'(sat_update(CTR_W_MAX'(sram_rdata_i), CTR_W_MAX'(CTR_MAX), head.taken));
        fifo_pop = 1'b1;
        if (flush_bht_i) begin
          fifo_clear = 1'b1;
          ptr_d      = '0;
          state_d    = INIT;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // A flushing cycle refuses new updates since the FIFO is being discarded anyway.
  assign upd_ready_o = (state_q != INIT) && !flush_bht_i && (!fifo_full || (state_q == UPD_WR));
  assign fifo_push   = upd_valid_i && upd_ready_o;

  assign init_busy_o     = (state_q == INIT);
  assign lookup_ready_o  = lookup_ready_c;
  assign lookup_rvalid_o = lookup_rv_q;
  assign lookup_ctr_o    = lookup_rv_q ? sram_rdata_i : '0;
  assign lookup_taken_o  = lookup_ctr_o[CTR_W-1];

  // SRAM command is combinational; hold it quiet while reset is asserted.
  assign sram_req_o   = req_c && !rst_i;
  assign sram_we_o    = we_c && !rst_i;
  assign sram_addr_o  = rst_i ? '0 : addr_c;
  assign sram_wdata_o = rst_i ? '0 : wdata_c;

`ifdef BHT_SCHED_STATS_EN
  logic [31:0] stall_q, upd_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
      upd_q   <= '0;
    end else begin
      if (lookup_valid_i && !lookup_ready_c) stall_q <= stall_q + 32'd1;
      if (state_q == UPD_WR)                 upd_q   <= upd_q + 32'd1;
    end
  end

  assign stat_stall_o = stall_q;
  assign stat_upd_o   = upd_q;
`else
  assign stat_stall_o = '0;
  assign stat_upd_o   = '0;
`endif

endmodule

// File: tb/tb_bht_port_sched.sv
// Bench for bht_port_sched: SRAM model, queue-based reference model compared every cycle,
// and directed scenarios with hand-computed expectations.
module tb_bht_port_sched;

  localparam int NR   = 16;
  localparam int CW   = 2;
  localparam int DEPTH = 4;
  localparam int IW   = 4;
  localparam int CMAX = 3;
`ifdef BHT_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_bht_i = 1'b0;
  logic          lookup_valid_i = 1'b0;
  logic [IW-1:0] lookup_index_i = '0;
  logic          upd_valid_i = 1'b0;
  logic [IW-1:0] upd_index_i = '0;
  logic          upd_taken_i = 1'b0;
  logic [CW-1:0] sram_rdata_i = '0;
  logic          lookup_ready_o, lookup_rvalid_o, lookup_taken_o;
  logic [CW-1:0] lookup_ctr_o, sram_wdata_o;
  logic          upd_ready_o, init_busy_o, sram_req_o, sram_we_o;
  logic [IW-1:0] sram_addr_o;
  logic [31:0]   stat_stall_o, stat_upd_o;

  bht_port_sched #(.NR_ENTRIES(NR)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_bht_i     (flush_bht_i),
    .lookup_valid_i  (lookup_valid_i),
    .lookup_index_i  (lookup_index_i),
    .lookup_ready_o  (lookup_ready_o),
    .lookup_rvalid_o (lookup_rvalid_o),
    .lookup_ctr_o    (lookup_ctr_o),
    .lookup_taken_o  (lookup_taken_o),
    .upd_valid_i     (upd_valid_i),
    .upd_index_i     (upd_index_i),
    .upd_taken_i     (upd_taken_i),
    .upd_ready_o     (upd_ready_o),
    .init_busy_o     (init_busy_o),
    .sram_req_o      (sram_req_o),
    .sram_we_o       (sram_we_o),
    .sram_addr_o     (sram_addr_o),
    .sram_wdata_o    (sram_wdata_o),
    .sram_rdata_i    (sram_rdata_i),
    .stat_stall_o    (stat_stall_o),
    .stat_upd_o      (stat_upd_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM macro: registered read, write does not disturb read data.
  logic [CW-1:0] mem [NR];
  int wr_cnt = 0;
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) begin
        mem[sram_addr_o] <= sram_wdata_o;
        wr_cnt <= wr_cnt + 1;
      end else begin
        sram_rdata_i <= mem[sram_addr_o];
      end
    end
  end

  // Reference model: expected counter contents, queue of pending updates, walk position.
  typedef struct { int idx; bit taken; } upd_t;
  int   gold [NR];
  upd_t m_q [$];
  bit   m_busy = 1'b1;
  int   m_walk = 0;
  bit   m_wr = 1'b0;
  bit   m_rv = 1'b0;
  int   m_rv_ctr = 0;
  int   m_stall = 0;
  int   m_upd = 0;

  function automatic int sat_model(input int v, input bit t);
    if (t) return (v < CMAX) ? v + 1 : v;
    return (v > 0) ? v - 1 : v;
  endfunction

  task automatic model_cycle();
    bit e_lr, e_ur, e_req, e_we, busy_now, nxt_rv;
    int e_addr, e_wd, nxt_rv_ctr;
    if (rst_i) begin
      check("rst_init_busy", init_busy_o, 1);
      check("rst_upd_ready", upd_ready_o, 0);
      check("rst_lookup_ready", lookup_ready_o, 0);
      check("rst_rvalid", lookup_rvalid_o, 0);
      check("rst_ctr", lookup_ctr_o, 0);
      check("rst_sram_req", sram_req_o, 0);
      check("rst_stat_stall", stat_stall_o, 0);
      check("rst_stat_upd", stat_upd_o, 0);
      m_busy = 1'b1; m_walk = 0; m_wr = 1'b0; m_rv = 1'b0;
      m_q.delete(); m_stall = 0; m_upd = 0;
      return;
    end
    e_lr = 0; e_ur = 0; e_req = 0; e_we = 0; e_addr = 0; e_wd = 0;
    nxt_rv = 0; nxt_rv_ctr = 0; busy_now = m_busy;
    check("rvalid", lookup_rvalid_o, m_rv);
    if (m_rv) begin
      check("lookup_ctr", lookup_ctr_o, m_rv_ctr);
      check("lookup_taken", lookup_taken_o, m_rv_ctr >> (CW - 1));
    end
    check("stat_stall", stat_stall_o, STATS ? m_stall : 0);
    check("stat_upd", stat_upd_o, STATS ? m_upd : 0);
    if (m_busy) begin
      e_req = 1; e_we = 1; e_addr = m_walk; e_wd = 1;
      gold[m_walk] = 1;
      if (flush_bht_i) m_walk = 0;
      else if (m_walk == NR - 1) begin m_walk = 0; m_busy = 0; end
      else m_walk++;
    end else if (m_wr) begin
      e_ur = !flush_bht_i;
      e_req = 1; e_we = 1; e_addr = m_q[0].idx;
      e_wd = sat_model(gold[m_q[0].idx], m_q[0].taken);
      gold[m_q[0].idx] = e_wd;
      void'(m_q.pop_front());
      m_upd++; m_wr = 0;
      if (flush_bht_i) begin m_q.delete(); m_busy = 1; m_walk = 0; end
    end else begin
      e_ur = !flush_bht_i && (m_q.size() < DEPTH);
      if (flush_bht_i) begin
        m_q.delete(); m_busy = 1; m_walk = 0;
      end else if (m_q.size() == DEPTH) begin
        e_req = 1; e_addr = m_q[0].idx; m_wr = 1;
      end else if (lookup_valid_i) begin
        e_req = 1; e_addr = int'(lookup_index_i); e_lr = 1;
        nxt_rv = 1; nxt_rv_ctr = gold[lookup_index_i];
      end else if (m_q.size() > 0) begin
        e_req = 1; e_addr = m_q[0].idx; m_wr = 1;
      end
    end
    check("init_busy", init_busy_o, busy_now);
    check("lookup_ready", lookup_ready_o, e_lr);
    check("upd_ready", upd_ready_o, e_ur);
    check("sram_req", sram_req_o, e_req);
    if (e_req) begin
      check("sram_we", sram_we_o, e_we);
      check("sram_addr", sram_addr_o, e_addr);
      if (e_we) check("sram_wdata", sram_wdata_o, e_wd);
    end
    if (upd_valid_i && e_ur) m_q.push_back('{int'(upd_index_i), upd_taken_i});
    if (lookup_valid_i && !e_lr) m_stall++;
    m_rv = nxt_rv; m_rv_ctr = nxt_rv_ctr;
  endtask

  always begin
    @(negedge clk_i);
    #2;
    model_cycle();
  end

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  function automatic int count_ones();
    int n = 0;
    for (int i = 0; i < NR; i++) if (mem[i] == 2'd1) n++;
    return n;
  endfunction

  initial begin
    int w0;
    // Reset and initial walk
    repeat (3) step();
    rst_i = 1'b0;
    repeat (16) step();
    #2;
    check("init_done_busy", init_busy_o, 0);
    check("init_writes", wr_cnt, 16);
    check("init_all_ones", count_ones(), NR);

    // Single lookup after init
    step(); lookup_valid_i = 1; lookup_index_i = 4'd5;
    step(); lookup_valid_i = 0;
    #2;
    check("t2_rvalid", lookup_rvalid_o, 1);
    check("t2_ctr", lookup_ctr_o, 1);
    check("t2_taken", lookup_taken_o, 0);

    // Three taken updates to index 5, idle
    step(); upd_valid_i = 1; upd_index_i = 4'd5; upd_taken_i = 1;
    step();
    step();
    step(); upd_valid_i = 0;
    repeat (8) step();
    check("t3_mem5", mem[5], 3);
    lookup_valid_i = 1; lookup_index_i = 4'd5;
    step(); lookup_valid_i = 0;
    #2;
    check("t3_ctr", lookup_ctr_o, 3);
    check("t3_taken", lookup_taken_o, 1);
    check("t3_stat_upd", stat_upd_o, STATS ? 3 : 0);

    // FIFO fills under continuous lookups, forcing one RMW
    for (int i = 0; i < 4; i++) begin
      step();
      lookup_valid_i = 1; lookup_index_i = 4'(i);
      upd_valid_i = 1; upd_index_i = 4'(8 + i); upd_taken_i = i[0];
    end
    step(); upd_valid_i = 0; lookup_index_i = 4'd7;
    #2;
    check("t4_stall1_ready", lookup_ready_o, 0);
    check("t4_full_upd_ready", upd_ready_o, 0);
    step();
    #2;
    check("t4_stall2_ready", lookup_ready_o, 0);
    check("t4_pop_upd_ready", upd_ready_o, 1);
    step();
    #2;
    check("t4_resume_ready", lookup_ready_o, 1);
    check("t4_stat_stall", stat_stall_o, STATS ? 2 : 0);
    repeat (3) step();
    lookup_valid_i = 0;
    repeat (12) step();

    // Lookup stream holds back two queued updates
    w0 = wr_cnt;
    for (int i = 0; i < 8; i++) begin
      step();
      lookup_valid_i = 1; lookup_index_i = 4'(i + 3);
      upd_valid_i = (i < 2); upd_index_i = 4'(12 + i); upd_taken_i = 1;
    end
    step(); lookup_valid_i = 0; upd_valid_i = 0;
    #2;
    check("t5_no_drain", wr_cnt - w0, 0);
    repeat (6) step();
    #2;
    check("t5_drained", wr_cnt - w0, 2);

    // Flush during UPD_WR
    step(); upd_valid_i = 1; upd_index_i = 4'd2; upd_taken_i = 1;
    step(); upd_index_i = 4'd3;
    step(); upd_index_i = 4'd4; flush_bht_i = 1; w0 = wr_cnt;
    #2;
    check("t6_flush_upd_ready", upd_ready_o, 0);
    check("t6_wr_we", sram_we_o, 1);
    check("t6_wr_addr", sram_addr_o, 2);
    step(); flush_bht_i = 0; upd_valid_i = 0;
    #2;
    check("t6_init_busy", init_busy_o, 1);
    check("t6_walk_addr", sram_addr_o, 0);
    check("t6_wr_done", wr_cnt - w0, 1);
    repeat (16) step();
    #2;
    check("t6_run_again", init_busy_o, 0);
    check("t6_all_ones", count_ones(), NR);

    // Lookup response survives a flush; flush restarts a walk in progress
    step(); lookup_valid_i = 1; lookup_index_i = 4'd6;
    step(); lookup_valid_i = 0; flush_bht_i = 1;
    #2;
    check("t7_rvalid_on_flush", lookup_rvalid_o, 1);
    check("t7_busy_before", init_busy_o, 0);
    step(); flush_bht_i = 0;
    #2;
    check("t7_busy_after", init_busy_o, 1);
    repeat (5) step();
    flush_bht_i = 1;
    step(); flush_bht_i = 0;
    #2;
    check("t7_walk_restart", sram_addr_o, 0);
    repeat (16) step();
    #2;
    check("t7_run_again", init_busy_o, 0);
    check("t7_all_ones", count_ones(), NR);

    // Reset in the middle of operation
    step(); lookup_valid_i = 1; lookup_index_i = 4'd1;
    upd_valid_i = 1; upd_index_i = 4'd3; upd_taken_i = 0;
    step(); upd_index_i = 4'd4;
    step(); rst_i = 1; lookup_valid_i = 0; upd_valid_i = 0;
    #2;
    check("t8_rst_busy", init_busy_o, 1);
    check("t8_rst_upd_ready", upd_ready_o, 0);
    step();
    step(); rst_i = 0;
    repeat (16) step();
    #2;
    check("t8_run_again", init_busy_o, 0);
    for (int i = 0; i < NR; i++) check("final_mem_vs_model", mem[i], gold[i]);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
